csr_regfile: RTL
================

CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 SHALL have ports: clk input 1, clock; reset input 1, synchronous active-high reset.
REQ-002 SHALL have CSR access ports: csr_num input 14, CSR address; csr_we input 1, write strobe; csr_wmask input 32, bit write mask; csr_wdata input 32, write data; csr_rvalue output 32, read data.
REQ-003 SHALL have exception ports: wb_ex input 1; wb_ecode input 6; wb_esubcode input 9; wb_pc input 32; wb_vaddr input 32; ertn_flush input 1.
REQ-004 SHALL have interrupt ports: hw_int_in input 8, hardware lines; ipi_int_in input 1; has_int output 1, pending enabled interrupt.
REQ-005 SHALL have redirect and counter ports: ex_entry output 32, EENTRY value; ertn_entry output 32, ERA value; cnt_value output 64, stable counter; cnt_tid output 32, TID value.

Function
REQ-006 SHALL implement CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, SAVE0-3 0x30-0x33, and TID 0x40; unimplemented numbers SHALL read 0 and ignore writes.
REQ-007 SHALL drive csr_rvalue combinationally from csr_num in the same cycle, reflecting register state before that cycle's clock edge.
REQ-008 SHALL, on csr_we, update the register at the next edge as (wdata & wmask) | (old & ~wmask); read-only fields are unchanged; ESTAT writes SHALL affect only IS[1:0].
REQ-009 SHALL, on wb_ex at the next edge:
- PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE; CRMD.PLV<=0, CRMD.IE<=0.
- ESTAT.Ecode<=wb_ecode, ESTAT.EsubCode<=wb_esubcode; ERA<=wb_pc.
- BADV<=wb_vaddr only when wb_ecode is ADE or ALE.
REQ-010 SHALL give wb_ex priority over csr_we in the same cycle; the CSR write SHALL be dropped.
REQ-011 SHALL, on ertn_flush without wb_ex, restore CRMD.PLV<=PRMD.PPLV and CRMD.IE<=PRMD.PIE at the next edge; if wb_ex is also asserted, wb_ex wins.
REQ-012 SHALL sample hw_int_in into ESTAT.IS[9:2] and ipi_int_in into ESTAT.IS[12] every cycle (one-cycle latency).
REQ-013 SHALL assert has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), combinational from registers.
REQ-014 SHALL tie ex_entry to EENTRY and ertn_entry to ERA.
REQ-015 SHALL increment a 64-bit stable counter every cycle; cnt_value SHALL wrap from all-ones to 0.

Reset
REQ-016 SHALL, on reset, set CRMD=0x00000008 (DA=1, PLV=0, IE=0) and all other CSRs, counter, and timer state to 0.
REQ-017 SHALL give reset priority over every other event; after reset, has_int=0, csr_rvalue follows csr_num, ex_entry=0, ertn_entry=0, cnt_value=0, cnt_tid=0.

Configuration
REQ-018 SHALL, with CSR_TIMER_EN defined, implement TCFG 0x41 (En bit0, Periodic bit1, InitVal[31:2]), TVAL 0x42 (read-only), and TICLR 0x44 (reads 0).
REQ-019 SHALL, with CSR_TIMER_EN, operate the timer as follows:
- TCFG write with En=1 loads TVAL<={InitVal,2'b00}.
- While En=1 and TVAL!=0, TVAL decrements by 1 each cycle.
- When TVAL goes 1->0, ESTAT.IS[11] is set; if Periodic, TVAL reloads on that edge; otherwise TVAL holds at 0.
REQ-020 SHALL, with CSR_TIMER_EN, clear ESTAT.IS[11] on a TICLR write with (wdata&wmask)[0]=1; a same-cycle timer expiry set SHALL win.
REQ-021 SHALL, without CSR_TIMER_EN, read 0 at 0x41/0x42/0x44, ignore writes there, and hold ESTAT.IS[11] at 0.

Structure
REQ-022 SHALL take CSR numbers, ECODE/ESUBCODE constants, and CRMD/PRMD/ESTAT/TCFG field positions from shared package csr_pkg.
REQ-023 SHALL place TCFG/TVAL countdown and expiry logic in sub-module csr_timer, instantiated only under CSR_TIMER_EN.

Verification
REQ-024 SHALL cover a masked write: write EENTRY=0xFFFFFFFF with mask 0x0000FFC0 over 0 -> csr_rvalue(0xC)=0x0000FFC0, ex_entry=0x0000FFC0.
REQ-025 SHALL cover exception with a simultaneous CSR write: CRMD=0x7 (PLV=3, IE=1); wb_ex with ecode ALE, pc=0x1C000100, vaddr=0x1003, plus a write to SAVE0 -> PRMD=0x7, CRMD.PLV=0, CRMD.IE=0, ERA=0x1C000100, BADV=0x1003, SAVE0 unchanged.
REQ-026 SHALL cover ertn after the REQ-025 exception: ertn_flush -> CRMD.PLV=3, CRMD.IE=1, ertn_entry=0x1C000100.
REQ-027 SHALL cover interrupt pending: ECFG.LIE=0x004, CRMD.IE=1, hw_int_in=0x01 -> has_int=1 one cycle later; clear IE -> has_int=0.
REQ-028 SHALL cover the timer (CSR_TIMER_EN): TCFG=0x00000013 (InitVal=4, Periodic, En) -> TVAL 16,15,...,1,0, IS[11]=1, reload to 16; TICLR=1 -> IS[11]=0. Without CSR_TIMER_EN, TVAL SHALL read 0.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR numbers, exception codes, field positions and write masks for csr_regfile.
package csr_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00c;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0b;
    localparam logic [5:0] ECODE_BRK = 6'h0c;
    localparam logic [5:0] ECODE_INE = 6'h0d;

    localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
    localparam logic [8:0] ESUBCODE_ADEM = 9'h001;

    localparam int CRMD_PLV_LO     = 0;
    localparam int CRMD_PLV_HI     = 1;
    localparam int CRMD_IE         = 2;
    localparam int CRMD_DA         = 3;
    localparam int PRMD_PPLV_LO    = 0;
    localparam int PRMD_PPLV_HI    = 1;
    localparam int PRMD_PIE        = 2;
    localparam int ESTAT_IS_TIMER  = 11;
    localparam int ESTAT_IS_IPI    = 12;
    localparam int ESTAT_ECODE_LO  = 16;
    localparam int ESTAT_ESUB_LO   = 22;
    localparam int TCFG_EN         = 0;
    localparam int TCFG_PERIODIC   = 1;
    localparam int TCFG_INITVAL_LO = 2;

    // Bits software may change through csr_we; everything else is read-only or hardware-owned.
    localparam logic [31:0] CRMD_WMASK   = 32'h0000_01ff;
    localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
    localparam logic [31:0] ECFG_WMASK   = 32'h0000_1fff;
    localparam logic [31:0] EENTRY_WMASK = 32'hffff_ffc0;
    localparam logic [31:0] TCFG_WMASK   = 32'hffff_ffff;
    localparam logic [31:0] CRMD_RESET   = 32'h0000_0008;

    function automatic logic [31:0] csr_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [31:0] wmask, input logic [31:0] field);
        return (old & ~(wmask & field)) | (wdata & wmask & field);
    endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// CSR read/write access bus between the pipeline (master) and csr_regfile (slave).
interface csr_regfile_if;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rvalue;

    modport master (output csr_num, csr_we, csr_wmask, csr_wdata, input csr_rvalue);
    modport slave  (input csr_num, csr_we, csr_wmask, csr_wdata, output csr_rvalue);
endinterface

// File: rtl/csr_timer.sv
// TCFG/TVAL countdown timer; expire pulses in the cycle whose edge takes TVAL from 1 to 0.
module csr_timer
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        tcfg_we,
    input  logic [31:0] tcfg_wvalue,
    output logic [31:0] tcfg,
    output logic [31:0] tval,
    output logic        expire
);
    logic [31:0] tcfg_reg;
    logic [31:0] tval_reg;

    assign tcfg   = tcfg_reg;
    assign tval   = tval_reg;
    assign expire = tcfg_reg[TCFG_EN] && (tval_reg == 32'd1) && !tcfg_we;

    // Periodic mode shows TVAL=0 for one cycle after expiry, then reloads from InitVal.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcfg_reg <= 32'b0;
            tval_reg <= 32'b0;
        end else if (tcfg_we) begin
            tcfg_reg <= tcfg_wvalue;
            if (tcfg_wvalue[TCFG_EN])
                tval_reg <= {tcfg_wvalue[31:TCFG_INITVAL_LO], 2'b00};
        end else if (tcfg_reg[TCFG_EN]) begin
            if (tval_reg != 32'b0)
                tval_reg <= tval_reg - 32'd1;
            else if (tcfg_reg[TCFG_PERIODIC])
                tval_reg <= {tcfg_reg[31:TCFG_INITVAL_LO], 2'b00};
        end
    end
endmodule

// File: rtl/csr_regfile.sv
// Control/status register file: exception entry/return, interrupt pending, stable counter.
// Define CSR_TIMER_EN to add the TCFG/TVAL/TICLR timer (csr_timer).
module csr_regfile
    import csr_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    csr_regfile_if.slave csr,
    input  logic         wb_ex,
    input  logic [5:0]   wb_ecode,
    input  logic [8:0]   wb_esubcode,
    input  logic [31:0]  wb_pc,
    input  logic [31:0]  wb_vaddr,
    input  logic         ertn_flush,
    input  logic [7:0]   hw_int_in,
    input  logic         ipi_int_in,
    output logic         has_int,
    output logic [31:0]  ex_entry,
    output logic [31:0]  ertn_entry,
    output logic [63:0]  cnt_value,
    output logic [31:0]  cnt_tid
);
    logic [31:0] crmd_reg, prmd_reg, ecfg_reg, era_reg, badv_reg, eentry_reg, tid_reg;
    logic [1:0]  is_sw_reg;
    logic [7:0]  is_hw_reg;
    logic        is_ipi_reg;
    logic [5:0]  ecode_reg;
    logic [8:0]  esubcode_reg;
    logic [63:0] cnt_reg;
    logic [3:0][31:0] save_value;
    logic [31:0] tcfg_value, tval_value;
    logic        is_timer;
    logic [12:0] is_value;
    logic [31:0] estat_value;
    logic [31:0] rvalue;
    logic [13:0] csr_num;
    logic [31:0] wdata, wmask;
    logic        wr_en;

    assign csr_num     = csr.csr_num;
    assign wdata       = csr.csr_wdata;
    assign wmask       = csr.csr_wmask;
    // An exception in writeback squashes the instruction's own CSR write.
    assign wr_en       = csr.csr_we & ~wb_ex;
    assign is_value    = {is_ipi_reg, is_timer, 1'b0, is_hw_reg, is_sw_reg};
    assign estat_value = {1'b0, esubcode_reg, ecode_reg, 3'b000, is_value};

    assign has_int    = crmd_reg[CRMD_IE] & |(is_value & ecfg_reg[12:0]);
    assign ex_entry   = eentry_reg;
    assign ertn_entry = era_reg;
    assign cnt_value  = cnt_reg;
    assign cnt_tid    = tid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_reg     <= CRMD_RESET;
            prmd_reg     <= 32'b0;
            ecfg_reg     <= 32'b0;
            era_reg      <= 32'b0;
            badv_reg     <= 32'b0;
            eentry_reg   <= 32'b0;
            tid_reg      <= 32'b0;
            is_sw_reg    <= 2'b0;
            is_hw_reg    <= 8'b0;
            is_ipi_reg   <= 1'b0;
            ecode_reg    <= 6'b0;
            esubcode_reg <= 9'b0;
            cnt_reg      <= 64'b0;
        end else begin
            is_hw_reg  <= hw_int_in;
            is_ipi_reg <= ipi_int_in;
            cnt_reg    <= cnt_reg + 64'd1;
            if (wr_en) begin
                case (csr_num)
                    CSR_CRMD:   crmd_reg   <= csr_merge(crmd_reg, wdata, wmask, CRMD_WMASK);
                    CSR_PRMD:   prmd_reg   <= csr_merge(prmd_reg, wdata, wmask, PRMD_WMASK);
                    CSR_ECFG:   ecfg_reg   <= csr_merge(ecfg_reg, wdata, wmask, ECFG_WMASK);
                    CSR_ESTAT:  is_sw_reg  <= (wdata[1:0] & wmask[1:0]) | (is_sw_reg & ~wmask[1:0]);
                    CSR_ERA:    era_reg    <= csr_merge(era_reg, wdata, wmask, 32'hffff_ffff);
                    CSR_BADV:   badv_reg   <= csr_merge(badv_reg, wdata, wmask, 32'hffff_ffff);
                    CSR_EENTRY: eentry_reg <= csr_merge(eentry_reg, wdata, wmask, EENTRY_WMASK);
                    CSR_TID:    tid_reg    <= csr_merge(tid_reg, wdata, wmask, 32'hffff_ffff);
                    default: ;
                endcase
            end
            if (wb_ex) begin
                prmd_reg[PRMD_PPLV_HI:PRMD_PPLV_LO] <= crmd_reg[CRMD_PLV_HI:CRMD_PLV_LO];
                prmd_reg[PRMD_PIE]                  <= crmd_reg[CRMD_IE];
                crmd_reg[CRMD_PLV_HI:CRMD_PLV_LO]   <= 2'b00;
                crmd_reg[CRMD_IE]                   <= 1'b0;
                ecode_reg    <= wb_ecode;
                esubcode_reg <= wb_esubcode;
                era_reg      <= wb_pc;
                if (wb_ecode == ECODE_ADE || wb_ecode == ECODE_ALE)
                    badv_reg <= wb_vaddr;
            end else if (ertn_flush) begin
                crmd_reg[CRMD_PLV_HI:CRMD_PLV_LO] <= prmd_reg[PRMD_PPLV_HI:PRMD_PPLV_LO];
                crmd_reg[CRMD_IE]                 <= prmd_reg[PRMD_PIE];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_save
            logic [31:0] save_reg;
            always_ff @(posedge clk) begin
                if (reset)
                    save_reg <= 32'b0;
                else if (wr_en && csr_num == CSR_SAVE0 + 14'(gi))
                    save_reg <= csr_merge(save_reg, wdata, wmask, 32'hffff_ffff);
            end
            assign save_value[gi] = save_reg;
        end
    endgenerate

`ifdef CSR_TIMER_EN
    logic timer_expire;
    logic ticlr_hit;
    logic is_timer_reg;

    csr_timer u_timer (
        .clk         (clk),
        .reset       (reset),
        .tcfg_we     (wr_en && csr_num == CSR_TCFG),
        .tcfg_wvalue (csr_merge(tcfg_value, wdata, wmask, TCFG_WMASK)),
        .tcfg        (tcfg_value),
        .tval        (tval_value),
        .expire      (timer_expire)
    );

    assign ticlr_hit = wr_en && (csr_num == CSR_TICLR) && wdata[0] && wmask[0];

    // A new expiry in the same cycle as a TICLR clear must not be lost.
    always_ff @(posedge clk) begin
        if (reset)
            is_timer_reg <= 1'b0;
        else if (timer_expire)
            is_timer_reg <= 1'b1;
        else if (ticlr_hit)
            is_timer_reg <= 1'b0;
    end
    assign is_timer = is_timer_reg;
`else
    assign tcfg_value = 32'b0;
    assign tval_value = 32'b0;
    assign is_timer   = 1'b0;
`endif

    always_comb begin
        rvalue = 32'b0;
        case (csr_num)
            CSR_CRMD:   rvalue = crmd_reg;
            CSR_PRMD:   rvalue = prmd_reg;
            CSR_ECFG:   rvalue = ecfg_reg;
            CSR_ESTAT:  rvalue = estat_value;
            CSR_ERA:    rvalue = era_reg;
            CSR_BADV:   rvalue = badv_reg;
            CSR_EENTRY: rvalue = eentry_reg;
            CSR_SAVE0:  rvalue = save_value[0];
            CSR_SAVE1:  rvalue = save_value[1];
            CSR_SAVE2:  rvalue = save_value[2];
            CSR_SAVE3:  rvalue = save_value[3];
            CSR_TID:    rvalue = tid_reg;
            CSR_TCFG:   rvalue = tcfg_value;
            CSR_TVAL:   rvalue = tval_value;
            default:    rvalue = 32'b0;
        endcase
    end
    assign csr.csr_rvalue = rvalue;
endmodule
